apu_envelope_unit: RTL and testbench



---
 rtl/apu_envelope_unit.sv | 74 +++++++
 tb/tb_apu_envelope_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/apu_envelope_unit.sv
// Volume envelope for one APU tone channel: control register, start flag, divider and decay counter.
// Latency: V is combinational from registers, so it reflects any update immediately after the edge.
// Backpressure: none; every write strobe and quarter-frame step is taken on the edge it appears.
module apu_envelope_unit (
  input  logic       ACLK1,
  input  logic       n_RES,
  input  logic       WR_Reg,
  input  logic       WR_LC,
  input  logic       n_LFO1,
  input  logic [7:0] DB,
  output logic [3:0] V
);

  // vol doubles as the constant volume and the divider reload period
  logic [3:0] vol;
  logic       const_vol;
  logic       loop_en;
  logic       start;
  logic [3:0] div;
  logic [3:0] decay;
  logic       step;

  assign step = ~n_LFO1;

  // Control register: volume/period, constant-volume and loop flags; DB[7:6] unused
  always_ff @(posedge ACLK1 or negedge n_RES) begin
    if (!n_RES) begin
      vol       <= 4'd0;
      const_vol <= 1'b0;
      loop_en   <= 1'b0;
    end else if (WR_Reg) begin
      vol       <= DB[3:0];
      const_vol <= DB[4];
      loop_en   <= DB[5];
    end
  end

  // Start flag: a length-counter write arms it and wins over a same-edge step clearing it
  always_ff @(posedge ACLK1 or negedge n_RES) begin
    if (!n_RES) begin
      start <= 1'b0;
    end else if (WR_LC) begin
      start <= 1'b1;
    end else if (step && start) begin
      start <= 1'b0;
    end
  end

  // Divider and decay counter stepped once per quarter-frame edge, using pre-edge state
  always_ff @(posedge ACLK1 or negedge n_RES) begin
    if (!n_RES) begin
      div   <= 4'd0;
      decay <= 4'd0;
    end else if (step) begin
      if (start) begin
        decay <= 4'd15;
        div   <= vol;
      end else if (div == 4'd0) begin
        div <= vol;
        if (decay != 4'd0) begin
          decay <= decay - 4'd1;
        end else if (loop_en) begin
          decay <= 4'd15;
        end
      end else begin
        div <= div - 4'd1;
      end
    end
  end

  // Mixer output: constant volume overrides the decay level
  assign V = const_vol ? vol : decay;

endmodule

// File: tb/tb_apu_envelope_unit.sv
module tb_apu_envelope_unit;

  logic       ACLK1 = 1'b0;
  logic       n_RES = 1'b0;
  logic       WR_Reg = 1'b0;
  logic       WR_LC = 1'b0;
  logic       n_LFO1 = 1'b1;
  logic [7:0] DB = 8'h00;
  logic [3:0] V;

  int checks = 0;
  int passes = 0;

  logic [3:0] exp_q[$];
  string      name_q[$];

  apu_envelope_unit dut (
    .ACLK1 (ACLK1),
    .n_RES (n_RES),
    .WR_Reg(WR_Reg),
    .WR_LC (WR_LC),
    .n_LFO1(n_LFO1),
    .DB    (DB),
    .V     (V)
  );

  always #5 ACLK1 = ~ACLK1;

  // Monitor: on every falling edge, pop pending expectations and compare against V
  initial begin
    forever begin
      @(negedge ACLK1);
      while (exp_q.size() > 0) begin
        logic [3:0] e;
        string      n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (V === e) passes++;
        else $display("FAIL %s: V=%0d expected %0d", n, V, e);
      end
    end
  end

  task automatic expect_v(input string n, input logic [3:0] e);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // One clock edge with the given strobes asserted
  task automatic drive(input logic wr, input logic lc, input logic lfo, input logic [7:0] d);
    @(negedge ACLK1);
    WR_Reg = wr;
    WR_LC  = lc;
    n_LFO1 = ~lfo;
    DB     = d;
    @(posedge ACLK1);
    #1;
    WR_Reg = 1'b0;
    WR_LC  = 1'b0;
    n_LFO1 = 1'b1;
  endtask

  // Single-cycle quarter-frame pulse followed by an idle edge
  task automatic pulse();
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge ACLK1);
    n_RES = 1'b0;
    @(negedge ACLK1);
    #1;
    n_RES = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    expect_v("reset_initial", 4'd0);
    @(negedge ACLK1);
    #1;
    n_RES = 1'b1;

    // Decay without loop, period 15
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h0F);
    for (int p = 1; p <= 500; p++) begin
      pulse();
      if (p == 1)   expect_v("decay_p1", 4'd15);
      if (p == 16)  expect_v("decay_p16", 4'd15);
      if (p == 17)  expect_v("decay_p17", 4'd14);
      if (p == 33)  expect_v("decay_p33", 4'd13);
      if (p == 129) expect_v("decay_p129", 4'd7);
      if (p == 225) expect_v("decay_p225", 4'd1);
      if (p == 241) expect_v("decay_p241", 4'd0);
      if (p == 257) expect_v("decay_p257", 4'd0);
      if (p == 500) expect_v("decay_p500", 4'd0);
    end

    // Looping decay, period 15
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h2F);
    for (int p = 1; p <= 273; p++) begin
      pulse();
      if (p == 241) expect_v("loop_p241", 4'd0);
      if (p == 257) expect_v("loop_p257", 4'd15);
      if (p == 273) expect_v("loop_p273", 4'd14);
    end

    // Fast period 0 with loop, then reset mid-sequence
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 8'h20);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    for (int p = 1; p <= 17; p++) begin
      pulse();
      expect_v("fast_step", (p == 17) ? 4'd15 : 4'(16 - p));
    end
    pulse();
    pulse();
    expect_v("fast_p19", 4'd13);
    @(negedge ACLK1);
    #2;
    n_RES = 1'b0;
    #1;
    expect_v("reset_mid", 4'd0);
    @(negedge ACLK1);
    #1;
    n_RES = 1'b1;
    for (int p = 1; p <= 3; p++) begin
      pulse();
      expect_v("post_reset_pulse", 4'd0);
    end

    // Constant volume, then switch back to decay level
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 8'h1A);
    expect_v("const_write", 4'd10);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    pulse();
    for (int p = 1; p <= 100; p++) begin
      pulse();
      if (p % 25 == 0) expect_v("const_hold", 4'd10);
    end
    drive(1'b1, 1'b0, 1'b0, 8'h0A);
    expect_v("const_off_decay", 4'd6);

    // Simultaneous WR_LC and step
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    pulse();
    for (int p = 1; p <= 10; p++) pulse();
    expect_v("simul_pre", 4'd5);
    drive(1'b0, 1'b1, 1'b1, 8'h00);
    expect_v("simul_lc_step", 4'd4);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    pulse();
    expect_v("simul_restart", 4'd15);

    // Simultaneous WR_Reg and step: divider reloads with the old period 3
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 8'h13);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    pulse();
    expect_v("reg_step_const", 4'd3);
    pulse();
    pulse();
    pulse();
    drive(1'b1, 1'b0, 1'b1, 8'h05);
    expect_v("reg_step_decay", 4'd14);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    pulse();
    pulse();
    pulse();
    expect_v("reg_step_div_hold", 4'd14);
    pulse();
    expect_v("reg_step_div_old", 4'd13);

    // Drain the scoreboard with a bound
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge ACLK1);
    @(negedge ACLK1);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL scoreboard_drain: %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
